// File: rtl/wb_port_if.sv
// -----------------------------------------------------------------------------
// wb_port_if
//   Bundle of every bus signal around the shared register-file write port.
//
//   Handshake rules:
//     A side : a_valid presents a writeback. If a_stall is high in the same
//              cycle, nothing from that request is taken and the requester
//              holds every a_* signal stable and retries the next cycle.
//     B side : a load return transfers on a cycle where b_valid && b_ready.
//              b_ready depends only on registered occupancy.
//     RF side: rd/pc/cpsr write strobes are single-cycle pulses; the data
//              outputs hold their last value while their strobe is low.
//
//   Modports:
//     slave  - the arbiter (consumes requests, drives the register file)
//     master - the surrounding pipeline / memory / register file
//
//   Parameters: DW data width, RW register-number width, QDEPTH FIFO depth
//   (sets the q_count width).
// -----------------------------------------------------------------------------
interface wb_port_if #(
  parameter int DW     = 32,
  parameter int RW     = 4,
  parameter int QDEPTH = 4
);
  logic                          a_valid;
  logic                          a_rd_en;
  logic [RW-1:0]                 a_rd_num;
  logic [DW-1:0]                 a_rd_val;
  logic                          a_pc_en;
  logic [DW-1:0]                 a_pc_val;
  logic                          a_cpsr_en;
  logic [DW-1:0]                 a_cpsr_val;
  logic                          a_stall;

  logic                          b_valid;
  logic                          b_ready;
  logic [RW-1:0]                 b_rd_num;
  logic [DW-1:0]                 b_rd_val;

  logic                          rd_write_en;
  logic [RW-1:0]                 rd_num;
  logic [DW-1:0]                 rd_val;
  logic                          pc_write_en;
  logic [DW-1:0]                 pc_out;
  logic                          cpsr_write_en;
  logic [DW-1:0]                 cpsr_out;
  logic [$clog2(QDEPTH+1)-1:0]   q_count;
  logic                          busy;

  modport slave (
    input  a_valid, a_rd_en, a_rd_num, a_rd_val, a_pc_en, a_pc_val,
           a_cpsr_en, a_cpsr_val, b_valid, b_rd_num, b_rd_val,
    output a_stall, b_ready, rd_write_en, rd_num, rd_val, pc_write_en,
           pc_out, cpsr_write_en, cpsr_out, q_count, busy
  );

  modport master (
    output a_valid, a_rd_en, a_rd_num, a_rd_val, a_pc_en, a_pc_val,
           a_cpsr_en, a_cpsr_val, b_valid, b_rd_num, b_rd_val,
    input  a_stall, b_ready, rd_write_en, rd_num, rd_val, pc_write_en,
           pc_out, cpsr_write_en, cpsr_out, q_count, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port (rd, pc, cpsr) between the
//   in-order writeback stage (A) and late load returns (B). B returns are
//   buffered in a QDEPTH-entry FIFO. A normally wins the rd port; a wait
//   counter forces B through after its head has lost MAX_WAIT times, and A
//   is stalled (all-or-nothing) in that cycle.
//
//   Ports:
//     clk    - clock
//     rst_n  - synchronous active-low reset
//     bus    - wb_port_if.slave: A request, B return, register-file outputs,
//              q_count and busy
//     stall_cnt / squash_cnt (only with WB_ARB_STATS_EN) - saturating
//              counts of stalled-A cycles and squashed pops
//
//   Optional feature macro: WB_ARB_STATS_EN
//
//   Outputs are registered: a grant in cycle N writes in cycle N+1.
//   WAW: an accepted A rd write to register X squashes every queued (and
//   same-cycle enqueued) B return to X, since those are older than A.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int QDEPTH   = 4,
  parameter int MAX_WAIT = 3,
  parameter int DW       = 32,
  parameter int RW       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_port_if.slave    bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] squash_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int WW = $clog2(MAX_WAIT + 2);

  // FIFO storage and control
  logic [RW-1:0]     num_q [QDEPTH];
  logic [DW-1:0]     val_q [QDEPTH];
  logic [QDEPTH-1:0] sq_q, sq_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WW-1:0]     wait_q, wait_d;

  // Registered register-file outputs
  logic              rd_we_q, rd_we_d;
  logic [RW-1:0]     rd_num_q, rd_num_d;
  logic [DW-1:0]     rd_val_q, rd_val_d;
  logic              pc_we_q, pc_we_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic              cpsr_we_q, cpsr_we_d;
  logic [DW-1:0]     cpsr_q, cpsr_d;

  // Arbitration terms
  logic              empty, head_sq, h, a_req, b_win, a_stall;
  logic              a_acc, a_rd_acc, push, pop, b_ready;
  logic [QDEPTH-1:0] ent_valid;

  assign empty    = (count_q == '0);
  assign head_sq  = !empty && sq_q[rd_ptr_q];
  assign h        = !empty && !sq_q[rd_ptr_q];
  assign a_req    = bus.a_valid && bus.a_rd_en;
  assign b_win    = h && (!a_req || (wait_q == WW'(MAX_WAIT)));
  assign a_stall  = a_req && b_win;
  // Any A request that is not stalled is taken, including pc/cpsr-only
  // requests in a cycle where B owns the rd port.
  assign a_acc    = bus.a_valid && !a_stall;
  assign a_rd_acc = a_acc && bus.a_rd_en;
  // No pop credit: readiness is purely the registered occupancy.
  assign b_ready  = (count_q < CW'(QDEPTH));
  assign push     = bus.b_valid && b_ready;
  // A squashed head drains in one cycle regardless of who owns the port.
  assign pop      = b_win || head_sq;

  // Entry i is occupied when its distance from the read pointer is below
  // the occupancy (pointer arithmetic wraps modulo QDEPTH).
  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q);
    end
  end

  // Squash marking, including the entry being written this cycle.
  always_comb begin
    sq_d = sq_q;
    if (a_rd_acc) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (ent_valid[i] && (num_q[i] == bus.a_rd_num)) begin
          sq_d[i] = 1'b1;
        end
      end
    end
    if (push) begin
      sq_d[wr_ptr_q] = a_rd_acc && (bus.b_rd_num == bus.a_rd_num);
    end
  end

  // Pointers, occupancy and starvation counter
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop || empty) begin
      wait_d = '0;
    end else if (h && !b_win && (wait_q != WW'(MAX_WAIT))) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Register-file write selection
  always_comb begin
    rd_we_d   = 1'b0;
    rd_num_d  = rd_num_q;
    rd_val_d  = rd_val_q;
    pc_we_d   = 1'b0;
    pc_d      = pc_q;
    cpsr_we_d = 1'b0;
    cpsr_d    = cpsr_q;
    if (b_win) begin
      rd_we_d  = 1'b1;
      rd_num_d = num_q[rd_ptr_q];
      rd_val_d = val_q[rd_ptr_q];
    end else if (a_rd_acc) begin
      rd_we_d  = 1'b1;
      rd_num_d = bus.a_rd_num;
      rd_val_d = bus.a_rd_val;
    end
    if (a_acc && bus.a_pc_en) begin
      pc_we_d = 1'b1;
      pc_d    = bus.a_pc_val;
    end
    if (a_acc && bus.a_cpsr_en) begin
      cpsr_we_d = 1'b1;
      cpsr_d    = bus.a_cpsr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_q      <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      rd_we_q   <= 1'b0;
      rd_num_q  <= '0;
      rd_val_q  <= '0;
      pc_we_q   <= 1'b0;
      pc_q      <= '0;
      cpsr_we_q <= 1'b0;
      cpsr_q    <= '0;
    end else begin
      sq_q      <= sq_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      rd_we_q   <= rd_we_d;
      rd_num_q  <= rd_num_d;
      rd_val_q  <= rd_val_d;
      pc_we_q   <= pc_we_d;
      pc_q      <= pc_d;
      cpsr_we_q <= cpsr_we_d;
      cpsr_q    <= cpsr_d;
    end
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      num_q[wr_ptr_q] <= bus.b_rd_num;
      val_q[wr_ptr_q] <= bus.b_rd_val;
    end
  end

  assign bus.a_stall       = a_stall;
  assign bus.b_ready       = b_ready;
  assign bus.rd_write_en   = rd_we_q;
  assign bus.rd_num        = rd_num_q;
  assign bus.rd_val        = rd_val_q;
  assign bus.pc_write_en   = pc_we_q;
  assign bus.pc_out        = pc_q;
  assign bus.cpsr_write_en = cpsr_we_q;
  assign bus.cpsr_out      = cpsr_q;
  assign bus.q_count       = count_q;
  assign bus.busy          = !empty || rd_we_q || pc_we_q || cpsr_we_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, squash_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (a_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (head_sq && (squash_cnt_q != 16'hFFFF)) begin
        squash_cnt_q <= squash_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Random traffic on both requesters. A queue-level reference model decides
//   each cycle's grant from the arbitration rules, checks the combinational
//   a_stall / b_ready, and pushes the expected registered outputs into
//   exp_q. A separate monitor pops and compares one record per clock.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  localparam int QDEPTH   = 4;
  localparam int MAX_WAIT = 3;
  localparam int DW       = 32;
  localparam int RW       = 4;
  localparam int CW       = $clog2(QDEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_if #(.DW(DW), .RW(RW), .QDEPTH(QDEPTH)) bus ();

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt, squash_cnt;
`endif

  wb_port_arbiter #(.QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          rd_we;
    logic [RW-1:0] rd_num;
    logic [DW-1:0] rd_val;
    logic          pc_we;
    logic [DW-1:0] pc;
    logic          cpsr_we;
    logic [DW-1:0] cpsr;
    logic [CW-1:0] qc;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one record per clock once the stimulus has started filling exp_q.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_write_en",   64'(bus.rd_write_en),   64'(e.rd_we));
        check("rd_num",        64'(bus.rd_num),        64'(e.rd_num));
        check("rd_val",        64'(bus.rd_val),        64'(e.rd_val));
        check("pc_write_en",   64'(bus.pc_write_en),   64'(e.pc_we));
        check("pc_out",        64'(bus.pc_out),        64'(e.pc));
        check("cpsr_write_en", 64'(bus.cpsr_write_en), 64'(e.cpsr_we));
        check("cpsr_out",      64'(bus.cpsr_out),      64'(e.cpsr));
        check("q_count",       64'(bus.q_count),       64'(e.qc));
        check("busy",          64'(bus.busy),          64'(e.busy));
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [RW-1:0] num;
    logic [DW-1:0] val;
    bit            sq;
  } ent_t;

  ent_t          mq[$];     // pending load returns, oldest first
  int            starve;    // cycles the live head has been passed over
  logic [RW-1:0] m_rd_num;
  logic [DW-1:0] m_rd_val, m_pc, m_cpsr;
  int            m_stalls, m_squashes;
  bit            hold_a, hold_b;

  task automatic model_reset();
    mq.delete();
    starve     = 0;
    m_rd_num   = '0;
    m_rd_val   = '0;
    m_pc       = '0;
    m_cpsr     = '0;
    m_stalls   = 0;
    m_squashes = 0;
    hold_a     = 0;
    hold_b     = 0;
  endtask

  // Reset cycle: whatever the inputs, all outputs clear and the queue empties.
  task automatic reset_cycle();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    bus.a_valid = $urandom_range(1);
    bus.a_rd_en = 1'b1;
    bus.b_valid = $urandom_range(1);
    #1;
    model_reset();
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input int a_pct, input int b_pct);
    exp_t e;
    bit rdy, push, empty, hsq, live, areq, bwin, stall, acc, a_rd_ok;
    @(negedge clk);
    rst_n = 1'b1;
    if (!hold_a) begin
      bus.a_valid    = ($urandom_range(99) < a_pct);
      bus.a_rd_en    = ($urandom_range(99) < 80);
      bus.a_rd_num   = RW'($urandom_range(3));
      bus.a_rd_val   = $urandom;
      bus.a_pc_en    = $urandom_range(1);
      bus.a_pc_val   = $urandom;
      bus.a_cpsr_en  = ($urandom_range(99) < 30);
      bus.a_cpsr_val = $urandom;
    end
    if (!hold_b) begin
      bus.b_valid  = ($urandom_range(99) < b_pct);
      bus.b_rd_num = RW'($urandom_range(3));
      bus.b_rd_val = $urandom;
    end
    #1;
    rdy   = (mq.size() < QDEPTH);
    push  = bus.b_valid && rdy;
    empty = (mq.size() == 0);
    hsq   = !empty && mq[0].sq;
    live  = !empty && !mq[0].sq;
    areq  = bus.a_valid && bus.a_rd_en;
    bwin  = live && (!areq || starve == MAX_WAIT);
    stall = areq && bwin;
    acc   = bus.a_valid && !stall;
    a_rd_ok = acc && bus.a_rd_en;
    check("a_stall", 64'(bus.a_stall), 64'(stall));
    check("b_ready", 64'(bus.b_ready), 64'(rdy));

    e = '0;
    if (bwin) begin
      e.rd_we  = 1'b1;
      m_rd_num = mq[0].num;
      m_rd_val = mq[0].val;
    end else if (a_rd_ok) begin
      e.rd_we  = 1'b1;
      m_rd_num = bus.a_rd_num;
      m_rd_val = bus.a_rd_val;
    end
    if (acc && bus.a_pc_en) begin
      e.pc_we = 1'b1;
      m_pc    = bus.a_pc_val;
    end
    if (acc && bus.a_cpsr_en) begin
      e.cpsr_we = 1'b1;
      m_cpsr    = bus.a_cpsr_val;
    end

    if (bwin || hsq || empty) starve = 0;
    else if (live && starve < MAX_WAIT) starve++;
    if (stall) m_stalls++;
    if (hsq) m_squashes++;
    if (bwin || hsq) void'(mq.pop_front());
    if (a_rd_ok) begin
      foreach (mq[i]) if (mq[i].num == bus.a_rd_num) mq[i].sq = 1;
    end
    if (push) begin
      ent_t n;
      n.num = bus.b_rd_num;
      n.val = bus.b_rd_val;
      n.sq  = a_rd_ok && (bus.b_rd_num == bus.a_rd_num);
      mq.push_back(n);
    end

    e.rd_num  = m_rd_num;
    e.rd_val  = m_rd_val;
    e.pc      = m_pc;
    e.cpsr    = m_cpsr;
    e.qc      = CW'(mq.size());
    e.busy    = (mq.size() != 0) || e.rd_we || e.pc_we || e.cpsr_we;
    exp_q.push_back(e);

    hold_a = stall;
    hold_b = bus.b_valid && !rdy;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.a_valid = 0; bus.a_rd_en = 0; bus.a_rd_num = '0; bus.a_rd_val = '0;
    bus.a_pc_en = 0; bus.a_pc_val = '0; bus.a_cpsr_en = 0; bus.a_cpsr_val = '0;
    bus.b_valid = 0; bus.b_rd_num = '0; bus.b_rd_val = '0;
    model_reset();
    reset_cycle();
    reset_cycle();

    for (int i = 0; i < 40; i++) drive_cycle(0, 40);     // B only
    for (int i = 0; i < 200; i++) drive_cycle(100, 70);  // A saturating: forced stalls, full FIFO
    for (int i = 0; i < 300; i++) drive_cycle($urandom_range(20, 90), $urandom_range(10, 90));
    // Mid-operation reset with returns queued
    for (int i = 0; i < 6; i++) drive_cycle(100, 100);
    reset_cycle();
    for (int i = 0; i < 300; i++) drive_cycle($urandom_range(30, 100), $urandom_range(20, 80));
    for (int i = 0; i < 20; i++) drive_cycle(0, 0);      // drain

    @(posedge clk);
    #2;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
`ifdef WB_ARB_STATS_EN
    check("stall_cnt",  64'(stall_cnt),  64'(m_stalls));
    check("squash_cnt", 64'(squash_cnt), 64'(m_squashes));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (rd, pc, cpsr) between two requesters.
  - Requester A: the in-order pipeline writeback stage (ALU/CMP/JMP/LD-hit results).
  - Requester B: late load returns from multi-cycle data memory.
- B returns are buffered in a small FIFO. A has priority, but a wait counter bounds B starvation by stalling A.
- Sits between the writeback stage / dmem return path and the register file.

Parameters:
- QDEPTH, 4, B return FIFO depth; power of 2, ≥2.
- MAX_WAIT, 3, cycles a non-empty FIFO head may lose arbitration before B is forced.
- DW, 32, data width of rd/pc/cpsr.
- RW, 4, register-number width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  A presents a writeback this cycle
- a_rd_en  in  1  A request includes an rd write
- a_rd_num  in  RW  A destination register
- a_rd_val  in  DW  A rd data
- a_pc_en  in  1  A request includes a pc write
- a_pc_val  in  DW  A pc data
- a_cpsr_en  in  1  A request includes a cpsr write
- a_cpsr_val  in  DW  A cpsr data
- a_stall  out  1  A not accepted; hold a_* stable and retry next cycle
- b_valid  in  1  load return valid
- b_ready  out  1  FIFO can accept a return
- b_rd_num  in  RW  load destination register
- b_rd_val  in  DW  load data
- rd_write_en  out  1  register-file rd write strobe
- rd_num  out  RW  register-file rd number
- rd_val  out  DW  register-file rd data
- pc_write_en  out  1  pc write strobe
- pc_out  out  DW  pc data
- cpsr_write_en  out  1  cpsr write strobe
- cpsr_out  out  DW  cpsr data
- q_count  out  $clog2(QDEPTH+1)  FIFO occupancy
- busy  out  1  FIFO non-empty or any write strobe high

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n. On reset:
  - FIFO is flushed and squash bits cleared; wait_cnt = 0.
  - All write-enables, rd_num, rd_val, pc_out and cpsr_out = 0.
  - q_count = 0.
  - A reset asserted mid-operation discards every queued return; nothing is written.
- Enqueue: a B return is enqueued when b_valid && b_ready. b_ready = (q_count < QDEPTH) and is computed from registered occupancy, with no same-cycle pop credit. When the FIFO is full (q_count == QDEPTH), b_ready = 0.
- Arbitration (combinational, each cycle):
  - A_req = a_valid && a_rd_en.
  - H = FIFO non-empty and head not squashed.
  - B wins iff H && (!A_req || wait_cnt == MAX_WAIT). Otherwise A wins.
  - a_stall = A_req && B wins. A requests without rd (a_rd_en = 0) are never stalled.
- A stall is all-or-nothing: the pc and cpsr parts of a stalled A request are also deferred.
- Output timing: outputs are registered with 1-cycle latency. A winner granted in cycle N drives its strobes as 1-cycle pulses in N+1. rd_num, rd_val, pc_out and cpsr_out hold their last value while the corresponding enable is low.
- Accepted A request: rd/pc/cpsr strobes follow a_rd_en, a_pc_en and a_cpsr_en.
- B grant: pops the head and writes rd.
- Squashed head: popped in one cycle with no rd write and no a_stall. A may win in the same cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle H is true and B loses.
  - Cleared on any pop and whenever the FIFO is empty.
- WAW ordering: all queued returns, and any return enqueued in the same cycle, are older than the current A write. When A rd is accepted with rd_num X, every valid FIFO entry with rd_num X is marked squashed. This includes an entry enqueued that cycle.
- Simultaneous push and pop: allowed; q_count is unchanged.
- FIFO pointers wrap modulo QDEPTH.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined:
  - Add output stall_cnt [15:0], which counts cycles with a_stall = 1.
  - Add output squash_cnt [15:0], which counts squashed pops.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Idle FIFO; A writes r3 = 0x11, pc = 0x40 → next cycle: rd_write_en = 1, rd_num = 3, rd_val = 0x11, pc_write_en = 1, pc_out = 0x40; a_stall is never asserted.
- B push r5 = 0xAA while A is idle → rd write r5 = 0xAA two cycles after b_valid; q_count goes 1 → 0.
- MAX_WAIT = 3; queue holds r7; A continuously writes r1 → A wins 3 cycles. In cycle 4, a_stall = 1 and r7 is written next cycle. A retries and its r1 write lands the following cycle.
- Queue holds r2 = 0x5; A writes r2 = 0x9 → r2 = 0x9 only; the queued entry pops squashed with no rd write. With WB_ARB_STATS_EN, squash_cnt = 1.
- Push 4 returns with A stalling the pipeline → b_ready = 0 at q_count = 4. A 5th b_valid is not accepted until a pop occurs.
- Reset (rst_n = 0 for 1 cycle) with q_count = 3 → q_count = 0, all strobes 0, and no queued write ever appears.
